adma_dm_src_axis_ord: RTL and testbench
=======================================

# adma_dm_src_axis_ord

In-order AXI-Stream source data mover for the ADMA data path; successor to the bypass/ROB stream source. It matches each incoming stream packet against a queued read-transaction descriptor (ID, length) and zeroes invalid bytes. It drops null beats and repairs malformed packets by padding short ones and draining long ones. Per-channel errors are sticky. It sits between the external AXI-Stream slave port and the DMA channel write side.

## Interface

- DMA_CHN_NUM, 4, number of DMA channels
- ATX_SRC_DATA_W, 256, TDATA width
- ATX_SRC_BYTE_AMT, ATX_SRC_DATA_W/8, TKEEP/TSTRB width
- MST_ID_W, 5, TID / transaction ID width
- ATX_LEN_W, 8, beat-count width (len = beats-1)
- ATX_NUM_OSTD, DMA_CHN_NUM, descriptor FIFO depth (power of 2, ≥2)
- aclk  in  1  clock; all logic on rising edge
- aresetn  in  1  synchronous active-low reset
- atx_arid  in  MST_ID_W  descriptor ID
- atx_arlen  in  ATX_LEN_W  descriptor length (beats-1)
- atx_vld / atx_rdy  in/out  1  descriptor handshake
- atx_rdata  out  ATX_SRC_DATA_W  output beat
- atx_rdata_last  out  1  final beat of current descriptor
- atx_rdata_vld / atx_rdata_rdy  out/in  1  output handshake
- atx_id  in  MST_ID_W ×DMA_CHN_NUM  ID owned by each channel
- atx_err_clr  in  1 ×DMA_CHN_NUM  clears channel error flag
- atx_src_err  out  1 ×DMA_CHN_NUM  sticky error flag
- s_tid_i  in  MST_ID_W  stream ID
- s_tdest_i  in  1  unused
- s_tdata_i  in  ATX_SRC_DATA_W
- s_tkeep_i, s_tstrb_i  in  ATX_SRC_BYTE_AMT
- s_tlast_i, s_tvalid_i  in  1
- s_tready_o  out  1

## Operation

- Descriptor FIFO: depth ATX_NUM_OSTD. atx_rdy = !full. Push on atx_vld&&atx_rdy. Simultaneous push+pop at full is not allowed (rdy low).
- Head registers: hid, hlen, beat counter cnt (ATX_LEN_W bits). Error channel = lowest c with atx_id[c]==hid; if none matches, no flag is set.
- FSM states:
  - IDLE: s_tready_o=0. If FIFO non-empty: pop into head, cnt=0, go XFER.
  - XFER: s_tready_o = out_free. Classify each accepted stream beat:
    - tkeep==0 (null): dropped, not counted. Its tlast is ignored.
    - TID≠hid: dropped, not counted, error flagged.
    - Otherwise forwarded with byte i = tdata byte i if tkeep[i]&tstrb[i], else 0.
    - If cnt==hlen: beat forwarded with last=1. If tlast=1, go IDLE. If tlast=0, flag error (long packet) and go DRAIN.
    - Else, if tlast=1: flag error (short packet), forward with last=0, cnt++, go PAD.
    - Else: cnt++.
  - PAD: s_tready_o=0. Emit all-zero beats when out_free, cnt++. The beat with cnt==hlen carries last=1, then go IDLE.
  - DRAIN: s_tready_o=1. Discard all beats. Go IDLE on the accepted beat with tlast=1 (any TID).
- Output register: single stage. out_free = !atx_rdata_vld || atx_rdata_rdy. Full throughput with rdy held high.
- Error flag: set on flagged event. Cleared by atx_err_clr[c]. Set wins over clear in the same cycle.

## Timing

- Reset: atx_rdata_vld=0, atx_rdata=0, atx_rdata_last=0, atx_src_err=all 0, s_tready_o=0, atx_rdy=1 (FIFO empty), FSM=IDLE, cnt=0.
- Reset mid-transfer discards FIFO contents, head, and any held output beat.
- Latency: a stream beat accepted in cycle N appears on atx_rdata in cycle N+1.
- Descriptor pushed into an empty FIFO at cycle N: popped at N+1, XFER from N+2. There is one bubble cycle per descriptor.
- atx_rdata/atx_rdata_last are held stable while vld&&!rdy.
- cnt compare is at full ATX_LEN_W width. arlen=2^ATX_LEN_W−1 must not wrap: last is asserted at cnt==hlen, before any increment.
- arlen=0: single beat. tlast on that beat is the correct end.

## Test plan

- Normal: push (id=3,len=3), stream 4 beats tid=3, tkeep all-1, last on beat 4. Expect 4 output beats, last on beat 4, no error, 1 cycle latency, back-to-back with rdy=1.
- Byte masking / null: tkeep=0x0000_000F, tstrb=0x0000_0005 → only bytes 0 and 2 non-zero. An interleaved tkeep=0 beat is dropped and not counted.
- Short packet: (id=1,len=3), tlast on beat 2. Expect 2 data beats plus 2 zero beats, last on the 4th. atx_src_err of the channel with atx_id=1 goes to 1. err_clr returns it to 0 the next cycle.
- Long packet: (id=2,len=1), 4 beats with tlast on beat 4. Expect 2 output beats, last on the 2nd; beats 3–4 drained; error set.
- TID mismatch plus backpressure: beat with tid=7 during id=3 is dropped and the error set. Toggle atx_rdata_rdy randomly; the output beat is held stable and no beat is lost or duplicated.
- FIFO full: push ATX_NUM_OSTD descriptors with no stream activity. atx_rdy=0 after the last push. A set and err_clr in the same cycle leave the flag set.

Source files
------------

// File: rtl/adma_dm_src_axis_ord.sv
// In-order AXI-Stream source mover: matches stream packets to queued read descriptors,
// masks invalid bytes, drops null/foreign beats, pads short packets and drains long ones.
module adma_dm_src_axis_ord #(
  parameter int DMA_CHN_NUM      = 4,
  parameter int ATX_SRC_DATA_W   = 256,
  parameter int ATX_SRC_BYTE_AMT = ATX_SRC_DATA_W/8,
  parameter int MST_ID_W         = 5,
  parameter int ATX_LEN_W        = 8,
  parameter int ATX_NUM_OSTD     = DMA_CHN_NUM
) (
  input  logic                            aclk,
  input  logic                            aresetn,
  input  logic [MST_ID_W-1:0]             atx_arid,
  input  logic [ATX_LEN_W-1:0]            atx_arlen,
  input  logic                            atx_vld,
  output logic                            atx_rdy,
  output logic [ATX_SRC_DATA_W-1:0]       atx_rdata,
  output logic                            atx_rdata_last,
  output logic                            atx_rdata_vld,
  input  logic                            atx_rdata_rdy,
  input  logic [DMA_CHN_NUM*MST_ID_W-1:0] atx_id,
  input  logic [DMA_CHN_NUM-1:0]          atx_err_clr,
  output logic [DMA_CHN_NUM-1:0]          atx_src_err,
  input  logic [MST_ID_W-1:0]             s_tid_i,
  input  logic                            s_tdest_i,
  input  logic [ATX_SRC_DATA_W-1:0]       s_tdata_i,
  input  logic [ATX_SRC_BYTE_AMT-1:0]     s_tkeep_i,
  input  logic [ATX_SRC_BYTE_AMT-1:0]     s_tstrb_i,
  input  logic                            s_tlast_i,
  input  logic                            s_tvalid_i,
  output logic                            s_tready_o
);

  localparam int PTR_W = $clog2(ATX_NUM_OSTD);

  typedef enum logic [1:0] {ST_IDLE, ST_XFER, ST_PAD, ST_DRAIN} state_t;

  logic [MST_ID_W-1:0]       r_fifo_id  [ATX_NUM_OSTD];
  logic [ATX_LEN_W-1:0]      r_fifo_len [ATX_NUM_OSTD];
  logic [PTR_W:0]            r_wptr, r_rptr;
  state_t                    r_state;
  logic [MST_ID_W-1:0]       r_hid;
  logic [ATX_LEN_W-1:0]      r_hlen, r_cnt;
  logic                      r_out_vld, r_out_last;
  logic [ATX_SRC_DATA_W-1:0] r_out_data;
  logic [DMA_CHN_NUM-1:0]    r_err;

  logic                      w_empty, w_full, w_push, w_pop;
  logic                      w_out_free, w_acc, w_null, w_tid_ok, w_at_end;
  logic                      w_fwd, w_pad, w_err_evt;
  logic [DMA_CHN_NUM-1:0]    w_match, w_err_sel;
  logic [ATX_SRC_DATA_W-1:0] w_mdata;
  logic                      w_unused;

  assign w_unused = s_tdest_i;

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[PTR_W] != r_rptr[PTR_W]) &&
                   (r_wptr[PTR_W-1:0] == r_rptr[PTR_W-1:0]);
  assign w_push  = atx_vld && !w_full;
  assign w_pop   = (r_state == ST_IDLE) && !w_empty;
  assign atx_rdy = !w_full;

  assign w_out_free = !r_out_vld || atx_rdata_rdy;
  assign s_tready_o = ((r_state == ST_XFER) && w_out_free) || (r_state == ST_DRAIN);
  assign w_acc      = s_tvalid_i && s_tready_o;
  assign w_null     = (s_tkeep_i == '0);
  assign w_tid_ok   = (s_tid_i == r_hid);
  assign w_at_end   = (r_cnt == r_hlen);
  assign w_fwd      = (r_state == ST_XFER) && w_acc && !w_null && w_tid_ok;
  assign w_pad      = (r_state == ST_PAD) && w_out_free;
  // Foreign TID, or tlast disagreeing with the descriptor length (short or long packet)
  assign w_err_evt  = (r_state == ST_XFER) && w_acc && !w_null &&
                      (!w_tid_ok || (w_at_end != s_tlast_i));

  for (genvar gi = 0; gi < ATX_SRC_BYTE_AMT; gi++) begin : g_byte
    assign w_mdata[gi*8 +: 8] = (s_tkeep_i[gi] && s_tstrb_i[gi]) ? s_tdata_i[gi*8 +: 8] : 8'h00;
  end

  for (genvar gi = 0; gi < DMA_CHN_NUM; gi++) begin : g_chn
    assign w_match[gi] = (atx_id[gi*MST_ID_W +: MST_ID_W] == r_hid);
  end

  // Lowest matching channel owns the error; no match means nobody is flagged
  assign w_err_sel = w_match & (~w_match + DMA_CHN_NUM'(1));

  always_ff @(posedge aclk) begin
    if (w_push) begin
      r_fifo_id[r_wptr[PTR_W-1:0]]  <= atx_arid;
      r_fifo_len[r_wptr[PTR_W-1:0]] <= atx_arlen;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_err  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + (PTR_W+1)'(1);
      if (w_pop)  r_rptr <= r_rptr + (PTR_W+1)'(1);
      r_err <= (r_err & ~atx_err_clr) | ({DMA_CHN_NUM{w_err_evt}} & w_err_sel);
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state    <= ST_IDLE;
      r_hid      <= '0;
      r_hlen     <= '0;
      r_cnt      <= '0;
      r_out_vld  <= 1'b0;
      r_out_last <= 1'b0;
      r_out_data <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!w_empty) begin
            r_hid   <= r_fifo_id[r_rptr[PTR_W-1:0]];
            r_hlen  <= r_fifo_len[r_rptr[PTR_W-1:0]];
            r_cnt   <= '0;
            r_state <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (w_fwd) begin
            // Compare before increment so a maximum-length descriptor never wraps
            if (w_at_end) begin
              r_state <= s_tlast_i ? ST_IDLE : ST_DRAIN;
            end else begin
              r_cnt <= r_cnt + ATX_LEN_W'(1);
              if (s_tlast_i) r_state <= ST_PAD;
            end
          end
        end
        ST_PAD: begin
          if (w_out_free) begin
            if (w_at_end) r_state <= ST_IDLE;
            else          r_cnt   <= r_cnt + ATX_LEN_W'(1);
          end
        end
        ST_DRAIN: begin
          if (w_acc && s_tlast_i) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase

      if (w_out_free) begin
        r_out_vld <= w_fwd || w_pad;
        if (w_fwd) begin
          r_out_data <= w_mdata;
          r_out_last <= w_at_end;
        end else if (w_pad) begin
          r_out_data <= '0;
          r_out_last <= w_at_end;
        end
      end
    end
  end

  assign atx_rdata      = r_out_data;
  assign atx_rdata_last = r_out_last;
  assign atx_rdata_vld  = r_out_vld;
  assign atx_src_err    = r_err;

endmodule

// File: tb/tb_adma_dm_src_axis_ord.sv
// Scoreboard bench for adma_dm_src_axis_ord: expected beats queued at stimulus time,
// compared by an output monitor; each scenario task checks flags and handshakes inline.
module tb_adma_dm_src_axis_ord;
  localparam int CHN = 4, DW = 256, BA = 32, IDW = 5, LW = 8, OSTD = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            aresetn;
  logic [IDW-1:0]  atx_arid;
  logic [LW-1:0]   atx_arlen;
  logic            atx_vld, atx_rdy;
  logic [DW-1:0]   atx_rdata;
  logic            atx_rdata_last, atx_rdata_vld, atx_rdata_rdy;
  logic [CHN*IDW-1:0] atx_id;
  logic [CHN-1:0]  atx_err_clr, atx_src_err;
  logic [IDW-1:0]  s_tid;
  logic            s_tdest;
  logic [DW-1:0]   s_tdata;
  logic [BA-1:0]   s_tkeep, s_tstrb;
  logic            s_tlast, s_tvalid, s_tready;

  int checks = 0;
  int errors = 0;
  logic [DW:0] exp_q[$];
  logic        rand_rdy = 1'b0;
  logic        hold_v = 1'b0;
  logic [DW:0] hold_b;

  adma_dm_src_axis_ord #(
    .DMA_CHN_NUM(CHN), .ATX_SRC_DATA_W(DW), .ATX_SRC_BYTE_AMT(BA),
    .MST_ID_W(IDW), .ATX_LEN_W(LW), .ATX_NUM_OSTD(OSTD)
  ) dut (
    .aclk(clk), .aresetn(aresetn),
    .atx_arid(atx_arid), .atx_arlen(atx_arlen), .atx_vld(atx_vld), .atx_rdy(atx_rdy),
    .atx_rdata(atx_rdata), .atx_rdata_last(atx_rdata_last),
    .atx_rdata_vld(atx_rdata_vld), .atx_rdata_rdy(atx_rdata_rdy),
    .atx_id(atx_id), .atx_err_clr(atx_err_clr), .atx_src_err(atx_src_err),
    .s_tid_i(s_tid), .s_tdest_i(s_tdest), .s_tdata_i(s_tdata),
    .s_tkeep_i(s_tkeep), .s_tstrb_i(s_tstrb), .s_tlast_i(s_tlast),
    .s_tvalid_i(s_tvalid), .s_tready_o(s_tready)
  );

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] r;
    for (int i = 0; i < DW/32; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  // Output monitor: stability while stalled, and in-order scoreboard on each handshake
  always @(negedge clk) begin
    if (aresetn && atx_rdata_vld) begin
      if (hold_v) begin
        checks++;
        if ({atx_rdata_last, atx_rdata} !== hold_b) begin
          errors++;
          $display("FAIL hold_stable got last=%0b data=%h exp last=%0b data=%h",
                   atx_rdata_last, atx_rdata, hold_b[DW], hold_b[DW-1:0]);
        end
      end
      if (atx_rdata_rdy) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL out_unexpected got last=%0b data=%h exp none", atx_rdata_last, atx_rdata);
        end else begin
          logic [DW:0] e;
          e = exp_q.pop_front();
          if ({atx_rdata_last, atx_rdata} !== e) begin
            errors++;
            $display("FAIL out_beat got last=%0b data=%h exp last=%0b data=%h",
                     atx_rdata_last, atx_rdata, e[DW], e[DW-1:0]);
          end else begin
            $display("beat ok last=%0b data=%h", atx_rdata_last, atx_rdata);
          end
        end
      end
      hold_v = !atx_rdata_rdy;
      hold_b = {atx_rdata_last, atx_rdata};
    end else begin
      hold_v = 1'b0;
    end
  end

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      atx_rdata_rdy = 1'($urandom_range(0, 1));
    end
  end

  task automatic push_desc(input logic [IDW-1:0] id, input logic [LW-1:0] len);
    atx_arid = id; atx_arlen = len; atx_vld = 1'b1;
    for (int t = 0; ; t++) begin
      @(negedge clk);
      if (atx_rdy) break;
      if (t > 200) begin
        checks++; errors++;
        $display("FAIL push_timeout got rdy=%0b exp 1", atx_rdy);
        break;
      end
    end
    @(posedge clk); #1;
    atx_vld = 1'b0;
    $display("desc id=%0d len=%0d", id, len);
  endtask

  task automatic send_beat(input logic [IDW-1:0] tid, input logic [DW-1:0] d,
                           input logic [BA-1:0] k, input logic [BA-1:0] s,
                           input logic l, output int waited);
    s_tid = tid; s_tdata = d; s_tkeep = k; s_tstrb = s; s_tlast = l; s_tvalid = 1'b1;
    waited = 0;
    forever begin
      @(negedge clk);
      if (s_tready) break;
      waited++;
      if (waited > 200) begin
        checks++; errors++;
        $display("FAIL beat_timeout got tready=%0b exp 1", s_tready);
        break;
      end
    end
    @(posedge clk); #1;
    s_tvalid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain got pending=%0d exp 0", name, exp_q.size());
    end
  endtask

  task automatic check_err(input string name, input logic [CHN-1:0] exp);
    checks++;
    if (atx_src_err !== exp) begin
      errors++;
      $display("FAIL %s got err=%b exp %b", name, atx_src_err, exp);
    end else $display("err %s ok err=%b", name, atx_src_err);
  endtask

  task automatic clear_err(input logic [CHN-1:0] m);
    atx_err_clr = m;
    @(posedge clk); #1;
    atx_err_clr = '0;
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks += 6;
    if (atx_rdata_vld !== 1'b0) begin errors++; $display("FAIL rst_vld got %b exp 0", atx_rdata_vld); end
    if (atx_rdata !== '0) begin errors++; $display("FAIL rst_data got %h exp 0", atx_rdata); end
    if (atx_rdata_last !== 1'b0) begin errors++; $display("FAIL rst_last got %b exp 0", atx_rdata_last); end
    if (atx_src_err !== '0) begin errors++; $display("FAIL rst_err got %b exp 0", atx_src_err); end
    if (s_tready !== 1'b0) begin errors++; $display("FAIL rst_tready got %b exp 0", s_tready); end
    if (atx_rdy !== 1'b1) begin errors++; $display("FAIL rst_atx_rdy got %b exp 1", atx_rdy); end
    aresetn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_normal();
    logic [DW-1:0] d;
    int w;
    push_desc(5'd3, 8'd3);
    for (int b = 0; b < 4; b++) begin
      d = rand_data();
      exp_q.push_back({(b == 3), d});
      send_beat(5'd3, d, '1, '1, (b == 3), w);
      if (b > 0) begin
        checks++;
        if (w != 0) begin errors++; $display("FAIL normal_b2b got wait=%0d exp 0", w); end
      end
      checks++;
      if (atx_rdata_vld !== 1'b1 || atx_rdata !== d || atx_rdata_last !== (b == 3)) begin
        errors++;
        $display("FAIL normal_latency got vld=%b last=%b data=%h exp vld=1 last=%0b data=%h",
                 atx_rdata_vld, atx_rdata_last, atx_rdata, (b == 3), d);
      end
    end
    wait_drain("normal");
    check_err("normal_err", 4'b0000);
  endtask

  task automatic test_mask_null();
    logic [DW-1:0] d, e, d2;
    int w;
    push_desc(5'd3, 8'd1);
    d = rand_data();
    e = '0;
    e[7:0]   = d[7:0];
    e[23:16] = d[23:16];
    exp_q.push_back({1'b0, e});
    send_beat(5'd3, d, 32'h0000_000F, 32'h0000_0005, 1'b0, w);
    checks++;
    if (atx_rdata !== e) begin errors++; $display("FAIL mask_bytes got %h exp %h", atx_rdata, e); end
    send_beat(5'd3, rand_data(), '0, '1, 1'b1, w);
    d2 = rand_data();
    exp_q.push_back({1'b1, d2});
    send_beat(5'd3, d2, '1, '1, 1'b1, w);
    wait_drain("mask_null");
    check_err("mask_null_err", 4'b0000);
  endtask

  task automatic test_short();
    logic [DW-1:0] d1, d2;
    int w;
    push_desc(5'd1, 8'd3);
    d1 = rand_data(); d2 = rand_data();
    exp_q.push_back({1'b0, d1});
    exp_q.push_back({1'b0, d2});
    exp_q.push_back({1'b0, {DW{1'b0}}});
    exp_q.push_back({1'b1, {DW{1'b0}}});
    send_beat(5'd1, d1, '1, '1, 1'b0, w);
    send_beat(5'd1, d2, '1, '1, 1'b1, w);
    wait_drain("short");
    check_err("short_err_set", 4'b0010);
    clear_err(4'b0010);
    check_err("short_err_clr", 4'b0000);
  endtask

  task automatic test_long();
    logic [DW-1:0] d;
    int w;
    push_desc(5'd2, 8'd1);
    for (int b = 0; b < 4; b++) begin
      d = rand_data();
      if (b < 2) exp_q.push_back({(b == 1), d});
      send_beat(5'd2, d, '1, '1, (b == 3), w);
    end
    wait_drain("long");
    check_err("long_err_set", 4'b0100);
    clear_err(4'b0100);
    check_err("long_err_clr", 4'b0000);
  endtask

  task automatic test_tid_backpressure();
    logic [DW-1:0] d;
    int w;
    push_desc(5'd3, 8'd3);
    rand_rdy = 1'b1;
    for (int b = 0; b < 5; b++) begin
      d = rand_data();
      if (b == 1) begin
        send_beat(5'd7, d, '1, '1, 1'b0, w);
      end else begin
        exp_q.push_back({(b == 4), d});
        send_beat(5'd3, d, '1, '1, (b == 4), w);
      end
    end
    wait_drain("tid_bp");
    rand_rdy = 1'b0;
    @(posedge clk); #2;
    atx_rdata_rdy = 1'b1;
    check_err("tid_err_set", 4'b0001);
    clear_err(4'b0001);
    check_err("tid_err_clr", 4'b0000);
  endtask

  task automatic test_fifo_full();
    logic [DW-1:0] d;
    int w;
    push_desc(5'd3, 8'd0);
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < OSTD; i++) push_desc(5'd3, 8'd0);
    checks++;
    if (atx_rdy !== 1'b0) begin errors++; $display("FAIL fifo_full_rdy got %b exp 0", atx_rdy); end
    atx_err_clr = 4'b0001;
    send_beat(5'd7, rand_data(), '1, '1, 1'b1, w);
    atx_err_clr = '0;
    check_err("set_wins_clr", 4'b0001);
    clear_err(4'b0001);
    check_err("set_wins_after_clr", 4'b0000);
    for (int i = 0; i < OSTD + 1; i++) begin
      d = rand_data();
      exp_q.push_back({1'b1, d});
      send_beat(5'd3, d, '1, '1, 1'b1, w);
    end
    wait_drain("fifo_full");
    checks++;
    if (atx_rdy !== 1'b1) begin errors++; $display("FAIL fifo_empty_rdy got %b exp 1", atx_rdy); end
    check_err("fifo_full_err", 4'b0000);
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] d;
    int w;
    push_desc(5'd3, 8'd3);
    atx_rdata_rdy = 1'b0;
    send_beat(5'd3, rand_data(), '1, '1, 1'b0, w);
    push_desc(5'd2, 8'd0);
    checks++;
    if (atx_rdata_vld !== 1'b1) begin errors++; $display("FAIL mid_held got vld=%b exp 1", atx_rdata_vld); end
    aresetn = 1'b0;
    @(posedge clk); #1;
    aresetn = 1'b1;
    atx_rdata_rdy = 1'b1;
    checks += 3;
    if (atx_rdata_vld !== 1'b0) begin errors++; $display("FAIL mid_rst_vld got %b exp 0", atx_rdata_vld); end
    if (atx_rdy !== 1'b1) begin errors++; $display("FAIL mid_rst_rdy got %b exp 1", atx_rdy); end
    if (s_tready !== 1'b0) begin errors++; $display("FAIL mid_rst_tready got %b exp 0", s_tready); end
    push_desc(5'd3, 8'd0);
    d = rand_data();
    exp_q.push_back({1'b1, d});
    send_beat(5'd3, d, '1, '1, 1'b1, w);
    wait_drain("mid_recover");
    check_err("mid_err", 4'b0000);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout got running exp finished");
    $fatal(1, "timeout");
  end

  initial begin
    aresetn = 1'b0;
    atx_arid = '0; atx_arlen = '0; atx_vld = 1'b0;
    atx_rdata_rdy = 1'b1;
    atx_id = {5'd1, 5'd2, 5'd1, 5'd3};
    atx_err_clr = '0;
    s_tid = '0; s_tdest = 1'b0; s_tdata = '0; s_tkeep = '0; s_tstrb = '0;
    s_tlast = 1'b0; s_tvalid = 1'b0;
    test_reset();
    test_normal();
    test_mask_null();
    test_short();
    test_long();
    test_tid_backpressure();
    test_fifo_full();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
